ps2_key_decoder: RTL

Consumes the byte stream from the PS/2 receiver (one scan code per strobe) and turns Set-2 sequences into key events. Tracks E0/F0 prefixes, Shift/Ctrl/Caps state and ASCII translation. Buffers events in a small FIFO with a valid/ready handshake towards the display/console logic. Sits directly downstream of the PS/2 receiver.

---
 rtl/kbd_pkg.sv | 31 +++
 rtl/ps2_key_decoder_if.sv | 14 +
 rtl/kbd_event_fifo.sv | 50 +++++
 rtl/ps2_key_decoder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared types and Set-2 constants for the PS/2 key decoder
package kbd_pkg;

    typedef enum logic [1:0] {
        KBD_IDLE     = 2'd0,
        KBD_PRE_E0   = 2'd1,
        KBD_PRE_F0   = 2'd2,
        KBD_PRE_E0F0 = 2'd3
    } kbd_state_e;

    localparam logic [7:0] PS2_E0     = 8'hE0;
    localparam logic [7:0] PS2_F0     = 8'hF0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;
    localparam logic [7:0] PS2_CTRL   = 8'h14;
    localparam logic [7:0] PS2_CAPS   = 8'h58;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
        logic [7:0] ascii;
    } kbd_event_t;

    // Keyboard housekeeping replies that never start a key sequence
    function automatic logic is_discard(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
               (b == 8'hFA) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// rtl/ps2_key_decoder_if.sv - key event valid/ready stream between decoder and console
interface ps2_key_decoder_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic [7:0] ev_ascii;
    logic       ev_break;
    logic       ev_ext;

    modport master (output ev_valid, ev_code, ev_ascii, ev_break, ev_ext,
                    input  ev_ready);
    modport slave  (input  ev_valid, ev_code, ev_ascii, ev_break, ev_ext,
                    output ev_ready);
endinterface

// File: rtl/kbd_event_fifo.sv
// rtl/kbd_event_fifo.sv - synchronous power-of-two FIFO holding decoded key events
module kbd_event_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign do_pop   = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - Set-2 scan code parser, modifier tracking, ASCII and event FIFO
// Optional typematic repeat filter: KBD_REPEAT_FILTER_EN
module ps2_key_decoder
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [7:0]              code_in,
    input  logic                    code_valid,
    ps2_key_decoder_if.master       ev,
    output logic                    shift_o,
    output logic                    ctrl_o,
    output logic                    caps_o,
    output logic [7:0]              press_cnt,
    output logic                    overflow
);
    localparam logic [1:0] ST_IDLE     = KBD_IDLE;
    localparam logic [1:0] ST_PRE_E0   = KBD_PRE_E0;
    localparam logic [1:0] ST_PRE_F0   = KBD_PRE_F0;
    localparam logic [1:0] ST_PRE_E0F0 = KBD_PRE_E0F0;

    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic ext,
                                                 input logic shift, input logic caps);
        logic [7:0] lc;
        logic [7:0] uc;
        logic       letter;
        {lc, uc} = 16'h0000;
        if (!ext) begin
            case (code)
                8'h1C: {lc, uc} = "aA";  8'h32: {lc, uc} = "bB";  8'h21: {lc, uc} = "cC";
                8'h23: {lc, uc} = "dD";  8'h24: {lc, uc} = "eE";  8'h2B: {lc, uc} = "fF";
                8'h34: {lc, uc} = "gG";  8'h33: {lc, uc} = "hH";  8'h43: {lc, uc} = "iI";
                8'h3B: {lc, uc} = "jJ";  8'h42: {lc, uc} = "kK";  8'h4B: {lc, uc} = "lL";
                8'h3A: {lc, uc} = "mM";  8'h31: {lc, uc} = "nN";  8'h44: {lc, uc} = "oO";
                8'h4D: {lc, uc} = "pP";  8'h15: {lc, uc} = "qQ";  8'h2D: {lc, uc} = "rR";
                8'h1B: {lc, uc} = "sS";  8'h2C: {lc, uc} = "tT";  8'h3C: {lc, uc} = "uU";
                8'h2A: {lc, uc} = "vV";  8'h1D: {lc, uc} = "wW";  8'h22: {lc, uc} = "xX";
                8'h35: {lc, uc} = "yY";  8'h1A: {lc, uc} = "zZ";
                8'h16: {lc, uc} = "1!";  8'h1E: {lc, uc} = "2@";  8'h26: {lc, uc} = "3#";
                8'h25: {lc, uc} = "4$";  8'h2E: {lc, uc} = "5%";  8'h36: {lc, uc} = "6^";
                8'h3D: {lc, uc} = "7&";  8'h3E: {lc, uc} = "8*";  8'h46: {lc, uc} = "9(";
                8'h45: {lc, uc} = "0)";
                8'h0E: {lc, uc} = 16'h607E;  8'h4E: {lc, uc} = 16'h2D5F;
                8'h55: {lc, uc} = 16'h3D2B;  8'h54: {lc, uc} = 16'h5B7B;
                8'h5B: {lc, uc} = 16'h5D7D;  8'h5D: {lc, uc} = 16'h5C7C;
                8'h4C: {lc, uc} = 16'h3B3A;  8'h52: {lc, uc} = 16'h2722;
                8'h41: {lc, uc} = 16'h2C3C;  8'h49: {lc, uc} = 16'h2E3E;
                8'h4A: {lc, uc} = 16'h2F3F;
                8'h29: {lc, uc} = 16'h2020;  8'h5A: {lc, uc} = 16'h0D0D;
                8'h66: {lc, uc} = 16'h0808;
                default: {lc, uc} = 16'h0000;
            endcase
        end
        letter = (lc >= 8'h61) && (lc <= 8'h7A);
        return (letter ? (shift ^ caps) : shift) ? uc : lc;
    endfunction

    logic [1:0] state;
    logic [1:0] state_next;
    logic       key_seen;
    logic       key_brk;
    logic       key_ext;
    logic       caps_held;

    always_comb begin
        state_next = state;
        key_seen   = 1'b0;
        key_brk    = 1'b0;
        key_ext    = 1'b0;
        if (code_valid) begin
            case (state)
                ST_IDLE: begin
                    if (code_in == PS2_E0)      state_next = ST_PRE_E0;
                    else if (code_in == PS2_F0) state_next = ST_PRE_F0;
                    else if (!is_discard(code_in)) key_seen = 1'b1;
                end
                ST_PRE_E0: begin
                    if (code_in == PS2_F0) state_next = ST_PRE_E0F0;
                    else if (code_in != PS2_E0) begin
                        key_seen = 1'b1; key_ext = 1'b1; state_next = ST_IDLE;
                    end
                end
                ST_PRE_F0: begin
                    if (code_in != PS2_F0) begin
                        key_seen = 1'b1; key_brk = 1'b1; state_next = ST_IDLE;
                    end
                end
                default: begin
                    if (code_in != PS2_E0 && code_in != PS2_F0) begin
                        key_seen = 1'b1; key_brk = 1'b1; key_ext = 1'b1; state_next = ST_IDLE;
                    end
                end
            endcase
        end
    end

    logic is_shift, is_ctrl, is_caps, key_ev, repeat_drop, push, pop;
    logic fifo_full, fifo_empty;
    kbd_event_t new_ev, head;

    assign is_shift = !key_ext && (code_in == PS2_LSHIFT || code_in == PS2_RSHIFT);
    assign is_ctrl  = (code_in == PS2_CTRL);
    assign is_caps  = !key_ext && (code_in == PS2_CAPS);
    assign key_ev   = key_seen && !(is_shift || is_ctrl || is_caps);
    assign push     = key_ev && !repeat_drop;
    assign pop      = ev.ev_valid && ev.ev_ready;

    assign new_ev = '{ext: key_ext, brk: key_brk, code: code_in,
                      ascii: scan_to_ascii(code_in, key_ext, shift_o, caps_o)};

`ifdef KBD_REPEAT_FILTER_EN
    logic       held_valid;
    logic       held_ext;
    logic [7:0] held_code;
    logic       held_match;

    assign held_match  = held_valid && (held_ext == key_ext) && (held_code == code_in);
    assign repeat_drop = !key_brk && held_match;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            held_valid <= 1'b0;
            held_ext   <= 1'b0;
            held_code  <= 8'h00;
        end else if (key_ev) begin
            if (!key_brk) begin
                held_valid <= 1'b1;
                held_ext   <= key_ext;
                held_code  <= code_in;
            end else if (held_match) begin
                held_valid <= 1'b0;
            end
        end
    end
`else
    assign repeat_drop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            shift_o   <= 1'b0;
            ctrl_o    <= 1'b0;
            caps_o    <= 1'b0;
            caps_held <= 1'b0;
            press_cnt <= 8'h00;
            overflow  <= 1'b0;
        end else begin
            state <= state_next;
            if (key_seen) begin
                if (is_shift) shift_o <= !key_brk;
                if (is_ctrl)  ctrl_o  <= !key_brk;
                // Caps toggles once per physical press; typematic makes are ignored
                if (is_caps) begin
                    if (!key_brk && !caps_held) caps_o <= !caps_o;
                    caps_held <= !key_brk;
                end
                if (key_ev && key_brk) press_cnt <= press_cnt + 8'd1;
            end
            if (push && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    kbd_event_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(kbd_event_t))) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (new_ev),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Head fields read as zero when empty so stale RAM never leaks out
    assign ev.ev_valid = !fifo_empty;
    assign ev.ev_code  = fifo_empty ? 8'h00 : head.code;
    assign ev.ev_ascii = fifo_empty ? 8'h00 : head.ascii;
    assign ev.ev_break = !fifo_empty && head.brk;
    assign ev.ev_ext   = !fifo_empty && head.ext;

endmodule
